// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared types and default widths for the ALU issue/capture stage.
package alu_issue_pkg;

  localparam int unsigned SETTLE_W  = 4;
  localparam int unsigned ALU_WIDTH = 8;
  localparam int unsigned ALU_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage : alu_issue_pkg

// File: rtl/alu_issue.sv
// alu_issue: registers a command onto the ALU inputs, waits SETTLE cycles,
// captures the ALU result and offers it downstream under valid/ready.
// Optional macro ALU_ISSUE_FLAGS_EN adds registered out_zero/out_parity flags.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_WIDTH,
  parameter int unsigned SEL_W  = ALU_SEL_W,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SEL_W-1:0] in_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_s,
  input  logic [WIDTH-1:0] alu_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [SEL_W-1:0] out_sel,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  // Reject out-of-range settle times at elaboration; the counter is not clamped.
  if (SETTLE == 0 || SETTLE > 15) begin : g_settle_range
    $error("alu_issue: SETTLE must be in 1..15");
  end

  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE - 1);

  state_e              state_q, state_d;
  logic                rdy_en_q;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [SEL_W-1:0]    alu_s_q, alu_s_d;
  logic [WIDTH-1:0]    out_r_q, out_r_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;
  logic                busy_q, busy_d;
  logic                accept;
`ifdef ALU_ISSUE_FLAGS_EN
  logic                out_zero_q, out_zero_d;
  logic                out_parity_q, out_parity_d;
`endif

  // Ready in IDLE, or in HOLD when the result leaves this cycle; masked on the release edge.
  assign in_ready = rdy_en_q &
                    ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready));
  assign accept   = in_valid & in_ready;

  // Next-state, operand load, settle countdown, result capture and op counting.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    out_r_d     = out_r_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
`ifdef ALU_ISSUE_FLAGS_EN
    out_zero_d   = out_zero_q;
    out_parity_d = out_parity_q;
`endif

    // Acceptance only happens in IDLE or HOLD and always restarts the settle wait.
    if (accept) begin
      alu_a_d  = in_a;
      alu_b_d  = in_b;
      alu_s_d  = in_sel;
      settle_d = SETTLE_LD;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (settle_q != '0) begin
          settle_d = settle_q - SETTLE_W'(1);
        end else begin
          out_r_d     = alu_r;
          out_sel_d   = alu_s_q;
          out_valid_d = 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
          out_zero_d   = (alu_r == '0);
          out_parity_d = ^alu_r;
`endif
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = accept ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_en_q    <= 1'b0;
      settle_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      out_r_q     <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
      busy_q      <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
      out_zero_q   <= 1'b0;
      out_parity_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      settle_q    <= settle_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      out_r_q     <= out_r_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
      busy_q      <= busy_d;
`ifdef ALU_ISSUE_FLAGS_EN
      out_zero_q   <= out_zero_d;
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign out_r     = out_r_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign op_count  = op_count_q;
  assign busy      = busy_q;
`ifdef ALU_ISSUE_FLAGS_EN
  assign out_zero   = out_zero_q;
  assign out_parity = out_parity_q;
`endif

endmodule : alu_issue
